data_mem_arbiter: RTL and testbench

DATA_MEM_ARBITER -- requirements
Module: data_mem_arbiter

---
 rtl/data_mem_arbiter.sv | 120 ++++++++++++
 tb/tb_data_mem_arbiter.sv | 268 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/data_mem_arbiter.sv
// Two-port arbiter onto a single data-memory port, three cycles per access.
// Define DATA_MEM_ARB_RR_EN for round-robin contention; otherwise port 0 has fixed priority.
module data_mem_arbiter #(
    parameter int ADDR_W = 16,
    parameter int DATA_W = 16
) (
    input  logic              clk,
    input  logic              rst,

    input  logic              req0,
    input  logic              we0,
    input  logic [ADDR_W-1:0] addr0,
    input  logic [DATA_W-1:0] wdata0,
    output logic              ack0,
    output logic [DATA_W-1:0] rdata0,

    input  logic              req1,
    input  logic              we1,
    input  logic [ADDR_W-1:0] addr1,
    input  logic [DATA_W-1:0] wdata1,
    output logic              ack1,
    output logic [DATA_W-1:0] rdata1,

    output logic [ADDR_W-1:0] mem_access_addr,
    output logic [DATA_W-1:0] mem_write_data,
    output logic              mem_write_en,
    output logic              mem_read_en,
    input  logic [DATA_W-1:0] mem_read_data,
    output logic              busy
);

    // state  | meaning
    // IDLE   | sample req0/req1, latch winner into sel
    // ACCESS | memory port driven from port sel; read data captured on exit
    // ACK    | one-cycle ack pulse to port sel
    typedef enum logic [1:0] {S_IDLE, S_ACCESS, S_ACK} state_t;

    state_t            state_q, state_d;
    logic              sel_q, sel_d;
    logic              ack0_q, ack1_q;
    logic [DATA_W-1:0] rdata0_q, rdata1_q;
    logic              win;
    logic              sel_we;
    logic [ADDR_W-1:0] sel_addr;
    logic [DATA_W-1:0] sel_wdata;
    logic              in_access;

`ifdef DATA_MEM_ARB_RR_EN
    logic              last_grant_q;

    always_comb begin
        if (req0 && req1) win = ~last_grant_q;
        else              win = req1 && !req0;
    end
`else
    always_comb begin
        win = !req0;
    end
`endif

    always_comb begin
        state_d = state_q;
        sel_d   = sel_q;
        case (state_q)
            S_IDLE: begin
                if (req0 || req1) begin
                    state_d = S_ACCESS;
                    sel_d   = win;
                end
            end
            S_ACCESS: state_d = S_ACK;
            S_ACK:    state_d = S_IDLE;
            default:  state_d = S_IDLE;
        endcase
    end

    assign sel_we    = sel_q ? we1    : we0;
    assign sel_addr  = sel_q ? addr1  : addr0;
    assign sel_wdata = sel_q ? wdata1 : wdata0;
    assign in_access = (state_q == S_ACCESS);

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= S_IDLE;
            sel_q    <= 1'b0;
            ack0_q   <= 1'b0;
            ack1_q   <= 1'b0;
            rdata0_q <= '0;
            rdata1_q <= '0;
`ifdef DATA_MEM_ARB_RR_EN
            last_grant_q <= 1'b1;
`endif
        end else begin
            state_q <= state_d;
            sel_q   <= sel_d;
            ack0_q  <= in_access && !sel_q;
            ack1_q  <= in_access &&  sel_q;
            if (in_access && !sel_we) begin
                if (sel_q) rdata1_q <= mem_read_data;
                else       rdata0_q <= mem_read_data;
            end
`ifdef DATA_MEM_ARB_RR_EN
            if (state_q == S_IDLE && (req0 || req1)) last_grant_q <= win;
`endif
        end
    end

    // Strobes are gated by rst so an access aborted by reset never commits.
    assign mem_access_addr = in_access ? sel_addr  : '0;
    assign mem_write_data  = in_access ? sel_wdata : '0;
    assign mem_write_en    = in_access &&  sel_we && !rst;
    assign mem_read_en     = in_access && !sel_we && !rst;

    assign ack0   = ack0_q;
    assign ack1   = ack1_q;
    assign rdata0 = rdata0_q;
    assign rdata1 = rdata1_q;
    assign busy   = (state_q != S_IDLE);

endmodule

// File: tb/tb_data_mem_arbiter.sv
// Scoreboard bench for data_mem_arbiter: directed requests push expected acks,
// a negedge monitor pops and compares; covers both arbitration builds.
module tb_data_mem_arbiter;
    localparam int AW = 16;
    localparam int DW = 16;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic          rst;
    logic          req0, we0, req1, we1;
    logic [AW-1:0] addr0, addr1;
    logic [DW-1:0] wdata0, wdata1;
    logic          ack0, ack1;
    logic [DW-1:0] rdata0, rdata1;
    logic [AW-1:0] mem_access_addr;
    logic [DW-1:0] mem_write_data;
    logic          mem_write_en, mem_read_en;
    logic [DW-1:0] mem_read_data;
    logic          busy;

    data_mem_arbiter #(.ADDR_W(AW), .DATA_W(DW)) dut (
        .clk(clk), .rst(rst),
        .req0(req0), .we0(we0), .addr0(addr0), .wdata0(wdata0), .ack0(ack0), .rdata0(rdata0),
        .req1(req1), .we1(we1), .addr1(addr1), .wdata1(wdata1), .ack1(ack1), .rdata1(rdata1),
        .mem_access_addr(mem_access_addr), .mem_write_data(mem_write_data),
        .mem_write_en(mem_write_en), .mem_read_en(mem_read_en),
        .mem_read_data(mem_read_data), .busy(busy)
    );

    logic [DW-1:0] mem [0:255];
    logic          load_mem;

    assign mem_read_data = mem[mem_access_addr[7:0]];

    always @(posedge clk) begin
        if (load_mem) begin
            for (int i = 0; i < 256; i++) mem[i] <= '0;
            mem[2] <= 16'h0BEE;
            mem[5] <= 16'h1234;
            mem[6] <= 16'h6666;
        end else if (mem_write_en) begin
            mem[mem_access_addr[7:0]] <= mem_write_data;
        end
    end

    typedef struct {
        int            port;
        logic [DW-1:0] rd;
    } exp_t;

    exp_t          sbq[$];
    exp_t          e;
    int            checks;
    int            failures;
    int            wcount;
    logic [DW-1:0] mon_rd0, mon_rd1;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            failures++;
            $display("FAIL %s actual=%h required=%h at %0t", name, act, req, $time);
        end
    endtask

    task automatic drive(input int p, input logic r, input logic w,
                         input logic [AW-1:0] a, input logic [DW-1:0] d);
        if (p == 0) begin req0 = r; we0 = w; addr0 = a; wdata0 = d; end
        else        begin req1 = r; we1 = w; addr1 = a; wdata1 = d; end
    endtask

    task automatic wait_idle();
        int guard = 0;
        while (busy && guard < 10) begin
            @(posedge clk); #1;
            guard++;
        end
        chk("wait_idle", busy, 0);
    endtask

    task automatic request(input int p, input logic w, input logic [AW-1:0] a,
                           input logic [DW-1:0] d, input logic [DW-1:0] rd_exp);
        int   n;
        logic got;
        wait_idle();
        sbq.push_back('{p, rd_exp});
        drive(p, 1'b1, w, a, d);
        n = 0;
        do begin
            @(posedge clk); #1;
            n++;
            if (n == 1) begin
                chk("acc_addr", mem_access_addr, a);
                chk("acc_we", mem_write_en, w);
                chk("acc_re", mem_read_en, !w);
                if (w) chk("acc_wdata", mem_write_data, d);
            end
            got = (p == 0) ? ack0 : ack1;
        end while (!got && n < 10);
        chk("ack_latency", n, 2);
        drive(p, 1'b0, 1'b0, '0, '0);
    endtask

    int            w0;
    int            n;
    int            grants;
    int            n_exp;
    logic [DW-1:0] mem2_before;

    initial begin
        rst = 1'b1; load_mem = 1'b1;
        checks = 0; failures = 0; wcount = 0;
        mon_rd0 = '0; mon_rd1 = '0;
        drive(0, 1'b0, 1'b0, '0, '0);
        drive(1, 1'b0, 1'b0, '0, '0);

        fork
            forever begin
                @(negedge clk);
                if (mem_write_en) wcount++;
                if (!busy || ack0 || ack1)
                    chk("mem_port_idle_zero",
                        {mem_access_addr, mem_write_data[14:0], mem_write_en, mem_read_en}, 0);
                if (rst) begin
                    mon_rd0 = '0;
                    mon_rd1 = '0;
                end else if (ack0 || ack1) begin
                    chk("ack_onehot", ack0 && ack1, 0);
                    if (sbq.size() == 0) begin
                        checks++;
                        failures++;
                        $display("FAIL unexpected_ack actual=ack0:%b,ack1:%b required=none at %0t",
                                 ack0, ack1, $time);
                    end else begin
                        e = sbq.pop_front();
                        chk("ack_port", ack1 ? 1 : 0, e.port);
                        if (e.port == 0) begin
                            chk("rdata0", rdata0, e.rd);
                            chk("rdata1_hold", rdata1, mon_rd1);
                            mon_rd0 = e.rd;
                        end else begin
                            chk("rdata1", rdata1, e.rd);
                            chk("rdata0_hold", rdata0, mon_rd0);
                            mon_rd1 = e.rd;
                        end
                    end
                end
            end
        join_none

        repeat (3) @(posedge clk);
        #1;
        rst = 1'b0; load_mem = 1'b0;
        chk("rst_busy", busy, 0);
        chk("rst_acks", {ack0, ack1}, 0);
        chk("rst_rdata0", rdata0, 0);
        chk("rst_rdata1", rdata1, 0);
        chk("rst_mem_port", {mem_access_addr, mem_write_en, mem_read_en}, 0);

        // port 0 write then read back
        w0 = wcount;
        request(0, 1'b1, 16'h0003, 16'hA5A5, 16'h0000);
        chk("wr_strobe_once", wcount - w0, 1);
        request(0, 1'b0, 16'h0003, 16'h0000, 16'hA5A5);
        chk("rd_no_strobe", wcount - w0, 1);

        // port 1 read of preloaded word, port 0 reads what port 1 wrote
        request(1, 1'b0, 16'h0005, 16'h0000, 16'h1234);
        request(1, 1'b1, 16'h0007, 16'h5A5A, 16'h1234);
        request(0, 1'b0, 16'h0007, 16'h0000, 16'h5A5A);
        chk("mem7_written", mem[7], 16'h5A5A);

        // reset during ACCESS of a port 1 write
        wait_idle();
        mem2_before = mem[2];
        w0 = wcount;
        drive(1, 1'b1, 1'b1, 16'h0002, 16'hFFFF);
        @(posedge clk); #1;
        chk("abort_in_access", busy, 1);
        rst = 1'b1;
        #1;
        chk("abort_we_forced", mem_write_en, 0);
        chk("abort_re_forced", mem_read_en, 0);
        drive(1, 1'b0, 1'b0, '0, '0);
        @(posedge clk); #1;
        rst = 1'b0;
        chk("abort_outputs_zero",
            {ack0, ack1, busy, rdata0, rdata1, mem_access_addr, mem_write_data,
             mem_write_en, mem_read_en}, 0);
        chk("abort_mem2", mem[2], mem2_before);
        chk("abort_no_strobe", wcount - w0, 0);
        repeat (4) @(posedge clk);
        #1;
        chk("abort_no_ack_pending", sbq.size(), 0);

        // contention, both requests held
`ifdef DATA_MEM_ARB_RR_EN
        n_exp = 4;
        sbq.push_back('{0, 16'h6666});
        sbq.push_back('{1, 16'h1234});
        sbq.push_back('{0, 16'h6666});
        sbq.push_back('{1, 16'h1234});
`else
        n_exp = 5;
        for (int k = 0; k < 4; k++) sbq.push_back('{0, 16'h6666});
        sbq.push_back('{1, 16'h1234});
`endif
        drive(0, 1'b1, 1'b0, 16'h0006, '0);
        drive(1, 1'b1, 1'b0, 16'h0005, '0);
        grants = 0;
        n = 0;
        while (grants < n_exp && n < 60) begin
            @(posedge clk); #1;
            n++;
            if (ack0 || ack1) begin
                grants++;
                if (grants == 4) begin
                    drive(0, 1'b0, 1'b0, '0, '0);
`ifdef DATA_MEM_ARB_RR_EN
                    drive(1, 1'b0, 1'b0, '0, '0);
`endif
                end
                if (grants == 5) drive(1, 1'b0, 1'b0, '0, '0);
            end
        end
        chk("contention_grants", grants, n_exp);
        chk("contention_cycles", n, 3 * n_exp - 1);
        drive(0, 1'b0, 1'b0, '0, '0);
        drive(1, 1'b0, 1'b0, '0, '0);

        // requests toggled during ACCESS/ACK are ignored
        wait_idle();
        w0 = wcount;
        sbq.push_back('{0, 16'h1234});
        drive(0, 1'b1, 1'b0, 16'h0005, '0);
        n = 0;
        do begin
            @(posedge clk); #1;
            n++;
            if (n == 1) begin
                req0 = 1'b0;
                drive(1, 1'b1, 1'b1, 16'h0002, 16'hFFFF);
            end
        end while (!ack0 && n < 10);
        chk("toggle_latency", n, 2);
        drive(0, 1'b0, 1'b0, '0, '0);
        drive(1, 1'b0, 1'b0, '0, '0);
        repeat (6) @(posedge clk);
        #1;
        chk("toggle_idle", busy, 0);
        chk("toggle_no_write", wcount - w0, 0);
        chk("toggle_mem2", mem[2], 16'h0BEE);

        repeat (3) @(posedge clk);
        #1;
        chk("scoreboard_drained", sbq.size(), 0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1);
    end

endmodule
